// File: rtl/serial_tx_rx.sv
`timescale 1ns/1ps
// UART-style link: SerialTx sends start/data(LSB first)/stop frames, SerialRx recovers them.
// Both halves share clk and an asynchronous active-high reset.

module serial_tx_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  output logic                 tx_busy,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_finish
);

  SerialTx #(
    .DATA_BITS    (DATA_BITS),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .tx_data   (tx_data),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy)
  );

  SerialRx #(
    .DATA_BITS    (DATA_BITS),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_finish (rx_finish)
  );

endmodule

module SerialTx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  output logic                 tx_busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  tx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shifted;
  logic                 serial_q;
  logic                 busy_q;

  assign shifted = shift_q >> 1;

  // NOTE: every register in a clocked block uses non-blocking assignment so all
  // flops see pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ce) begin
            shift_q  <= tx_data;
            cnt_q    <= '0;
            serial_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            bit_q    <= '0;
            serial_q <= shift_q[0];
            state_q  <= DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bit_q == BIT_LAST) begin
              serial_q <= 1'b1;
              state_q  <= STOP;
            end else begin
              bit_q    <= bit_q + 1'b1;
              shift_q  <= shifted;
              serial_q <= shifted[0];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          // busy drops on the edge that ends the stop bit; a held ce restarts one cycle later
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;

endmodule

module SerialRx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_finish
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;

  rx_state_e            state_q;
  logic                 sync1_q;
  logic                 sync2_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 finish_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: synchroniser flops reset to the idle line level so leaving reset
      // never looks like a falling start edge.
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      finish_q <= 1'b0;
    end else begin
      sync1_q  <= rx_serial;
      sync2_q  <= sync1_q;
      finish_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // the detecting cycle already counts toward the half-bit wait
          if (!sync2_q) begin
            cnt_q   <= CW'(1);
            bit_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= sync2_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) state_q <= STOP;
            else                   bit_q   <= bit_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (sync2_q) begin
              data_q   <= shift_q;
              finish_q <= 1'b1;
              state_q  <= IDLE;
            end else begin
              state_q <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BREAK: begin
          if (sync2_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_finish = finish_q;

endmodule

// File: tb/tb_serial_tx_rx.sv
`timescale 1ns/1ps
// Bench for serial_tx_rx: loopback frames, continuous streaming, glitches, framing errors,
// baud-rate mismatch and mid-frame reset, checked against a frame-level reference model.
module tb_serial_tx_rx;

  localparam int DB     = 8;
  localparam int CPB    = 8;
  localparam int FRAME  = (DB + 2) * CPB;
  localparam int PERIOD = FRAME + 1;
  // ce is driven on a falling edge and sampled on the next rising edge; rx_finish
  // is then seen on the falling edge 78 cycles after that start edge.
  localparam int RX_LAT = 79;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [DB-1:0] tx_data;
  logic          tx_serial;
  logic          tx_busy;
  logic          rx_serial;
  logic [DB-1:0] rx_data;
  logic          rx_finish;
  logic          loop_en;
  logic          drv_line;

  assign rx_serial = loop_en ? tx_serial : drv_line;

  serial_tx_rx #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .tx_data   (tx_data),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_finish (rx_finish)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every received word and the cycle it arrived on.
  logic [DB-1:0] rx_q[$];
  int unsigned   rx_t[$];
  int            long_pulse = 0;
  logic          fin_prev   = 1'b0;
  always @(negedge clk) begin
    if (rx_finish === 1'b1) begin
      rx_q.push_back(rx_data);
      rx_t.push_back(cyc);
    end
    if (rx_finish === 1'b1 && fin_prev === 1'b1) long_pulse++;
    fin_prev = rx_finish;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level during bit slot j of a frame carrying word.
  function automatic logic frame_bit(input logic [DB-1:0] word, input int j);
    if (j == 0)  return 1'b0;
    if (j <= DB) return word[j-1];
    return 1'b1;
  endfunction

  logic [DB-1:0] exp_rx_data = '0;

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
  endtask

  // Loopback one word with a one-cycle ce pulse and check line, busy and reception.
  task automatic send_frame(input logic [DB-1:0] word, input string tag);
    int unsigned c0;
    int bad_ser;
    int bad_busy;
    bad_ser  = 0;
    bad_busy = 0;
    clear_rx();
    loop_en = 1'b1;
    @(negedge clk);
    tx_data = word;
    ce      = 1'b1;
    c0      = cyc;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      ce      = 1'b0;
      tx_data = ~word;
      if (tx_serial !== frame_bit(word, k / CPB)) bad_ser++;
      if (tx_busy !== 1'b1) bad_busy++;
    end
    check({tag, " line pattern errors"}, 32'(bad_ser), 32'd0);
    check({tag, " busy low cycles"}, 32'(bad_busy), 32'd0);
    @(negedge clk);
    check({tag, " busy after frame"}, 32'(tx_busy), 32'd0);
    check({tag, " line idle after frame"}, 32'(tx_serial), 32'd1);
    repeat (20) @(negedge clk);
    check({tag, " rx pulses"}, 32'(rx_q.size()), 32'd1);
    check({tag, " rx word"}, 32'(rx_q.size() > 0 ? rx_q[0] : 'x), 32'(word));
    check({tag, " rx latency"}, rx_t.size() > 0 ? 32'(rx_t[0] - c0) : 'x, 32'(RX_LAT));
    exp_rx_data = word;
  endtask

  // Drive a frame on rx_serial directly, with a bit time that need not match the clock.
  task automatic drive_frame(input logic [DB-1:0] word, input logic stop_bit, input realtime bit_ns);
    for (int j = 0; j < DB + 2; j++) begin
      drv_line = (j == DB + 1) ? stop_bit : frame_bit(word, j);
      #(bit_ns);
    end
    drv_line = 1'b1;
  endtask

  logic [DB-1:0] exp_q[$];
  int unsigned   c_start;
  int            bad_idle;
  logic [DB-1:0] w;
  realtime       bit_times[2] = '{77.6, 82.4};

  initial begin
    rst      = 1'b0;
    ce       = 1'b0;
    tx_data  = '0;
    loop_en  = 1'b1;
    drv_line = 1'b1;
    #2 rst = 1'b1;

    // Reset values, then a quiet line for 200 cycles with ce low.
    repeat (3) @(negedge clk);
    check("reset tx_serial", 32'(tx_serial), 32'd1);
    check("reset tx_busy", 32'(tx_busy), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset rx_finish", 32'(rx_finish), 32'd0);
    rst = 1'b0;
    bad_idle = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || rx_data !== '0 || rx_finish !== 1'b0) bad_idle++;
    end
    check("idle after reset", 32'(bad_idle), 32'd0);

    // Single frames, including all-zero and all-one payloads.
    send_frame(8'hA5, "A5");
    send_frame(8'h00, "00");
    send_frame(8'hFF, "FF");
    for (int n = 0; n < 4; n++) send_frame(DB'($urandom), "random");

    // Continuous stream: ce held high, new word every 1500 cycles, 30 words.
    clear_rx();
    exp_q.delete();
    c_start = 0;
    for (int i = 0; i < 30 * 1500; i++) begin
      @(negedge clk);
      if (i == 0) c_start = cyc;
      if (i % 1500 == 0) tx_data = DB'($urandom);
      ce = 1'b1;
      if (i % PERIOD == 0) exp_q.push_back(tx_data);
    end
    @(negedge clk);
    ce = 1'b0;
    repeat (FRAME + 100) @(negedge clk);
    check("stream frame count", 32'(rx_q.size()), 32'(exp_q.size()));
    check("stream first latency", rx_t.size() > 0 ? 32'(rx_t[0] - c_start) : 'x, 32'(RX_LAT));
    for (int j = 0; j < exp_q.size() && j < rx_q.size(); j++) begin
      check("stream word", 32'(rx_q[j]), 32'(exp_q[j]));
      if (j > 0) check("stream period", 32'(rx_t[j] - rx_t[j-1]), 32'(PERIOD));
    end
    exp_rx_data = exp_q[exp_q.size() - 1];
    check("rx_finish pulse width", 32'(long_pulse), 32'd0);

    // Two-cycle low glitch on the line.
    drv_line = 1'b1;
    loop_en  = 1'b0;
    repeat (20) @(negedge clk);
    clear_rx();
    drv_line = 1'b0;
    repeat (2) @(negedge clk);
    drv_line = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch rx pulses", 32'(rx_q.size()), 32'd0);
    check("glitch rx_data held", 32'(rx_data), 32'(exp_rx_data));

    // Framing error (stop bit 0), then a good frame.
    drive_frame(DB'($urandom), 1'b0, 80.0);
    repeat (30) @(negedge clk);
    check("framing rx pulses", 32'(rx_q.size()), 32'd0);
    check("framing rx_data held", 32'(rx_data), 32'(exp_rx_data));
    w = DB'($urandom);
    drive_frame(w, 1'b1, 80.0);
    repeat (30) @(negedge clk);
    check("post-error rx pulses", 32'(rx_q.size()), 32'd1);
    check("post-error rx word", 32'(rx_q.size() > 0 ? rx_q[0] : 'x), 32'(w));

    // Sender bit time off by -3 % and +3 %.
    for (int b = 0; b < 2; b++) begin
      clear_rx();
      w = DB'($urandom);
      drive_frame(w, 1'b1, bit_times[b]);
      repeat (30) @(negedge clk);
      check("baud skew rx pulses", 32'(rx_q.size()), 32'd1);
      check("baud skew rx word", 32'(rx_q.size() > 0 ? rx_q[0] : 'x), 32'(w));
    end

    // Reset 40 cycles into a loopback frame.
    loop_en = 1'b1;
    repeat (10) @(negedge clk);
    clear_rx();
    tx_data = DB'($urandom);
    ce      = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid-frame reset tx_serial", 32'(tx_serial), 32'd1);
    check("mid-frame reset tx_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("mid-frame reset rx pulses", 32'(rx_q.size()), 32'd0);
    check("mid-frame reset rx_data", 32'(rx_data), 32'd0);
    send_frame(DB'($urandom), "after reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_tx_rx.md
# serial_tx_rx

Asynchronous serial (UART-style) transmitter/receiver pair on a single clock domain: 8N1-style frames (start, DATA_BITS data LSB first, one stop), fixed clocks-per-bit. The transmitter serialises a parallel word on request. The receiver recovers words from a serial line and flags each completed frame. It is the byte-level link layer between on-chip logic and an external serial pin. It is implemented as two submodules, SerialTx and SerialRx, which share clk and rst.

## Interface
Parameters (both submodules, positional order DATA_BITS then CLKS_PER_BIT):
- DATA_BITS, 8, payload bits per frame
- CLKS_PER_BIT, 8, clock cycles per serial bit (≥4, even)

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- ce  in  1  transmit request (SerialTx), level-sensitive
- tx_data  in  DATA_BITS  word to send (SerialTx)
- tx_serial  out  1  serial line out, idle high (SerialTx)
- tx_busy  out  1  transmitter busy (SerialTx)
- rx_serial  in  1  serial line in (SerialRx)
- rx_data  out  DATA_BITS  last correctly received word (SerialRx)
- rx_finish  out  1  one-cycle pulse per valid frame (SerialRx)

## Operation
Frame format: start bit 0, DATA_BITS data bits LSB first, stop bit 1. Each bit lasts CLKS_PER_BIT cycles. The line idles at 1.

Transmitter, states IDLE, START, DATA, STOP:
- IDLE: tx_serial=1, tx_busy=0. If ce=1 at a clock edge, latch tx_data into a shift register, go to START, tx_busy=1.
- START: drive 0 for CLKS_PER_BIT cycles.
- DATA: drive shift-register bit 0 for CLKS_PER_BIT cycles, then shift right. Repeat for DATA_BITS bits.
- STOP: drive 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Changes to tx_data or ce while busy are ignored. The word is latched only at frame start.
- If ce is held high, frames repeat back-to-back with one IDLE cycle between them. Each frame sends the tx_data value present at its start.

Receiver, states IDLE, START, DATA, STOP:
- rx_serial passes through a 2-flop synchroniser whose flops reset to 1.
- IDLE: wait for the synchronised line to be 0, then go to START and clear the bit counter.
- START: after CLKS_PER_BIT/2 cycles (mid-bit), resample. If the line is 0, go to DATA. If it is 1 (glitch), return to IDLE.
- DATA: every CLKS_PER_BIT cycles sample one bit and shift it in from the MSB side, so the first bit received ends up as bit 0. After DATA_BITS samples, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample mid-stop.
  - If the line is 1: load rx_data from the shift register, pulse rx_finish for one cycle, return to IDLE.
  - If the line is 0 (framing error): rx_data is unchanged, no pulse, wait until the line is 1, then return to IDLE.
- rx_data holds its value until the next valid frame.

## Timing
- Reset values: tx_serial=1, tx_busy=0, rx_data=0, rx_finish=0. Both FSMs go to IDLE and counters clear.
- Reset asserted mid-frame aborts immediately. tx_serial returns to 1 and no partial word or rx_finish is produced.
- Tx: ce sampled high in IDLE at edge N gives tx_serial=0 and tx_busy=1 from edge N+1. The frame occupies (DATA_BITS+2)·CLKS_PER_BIT cycles. tx_busy falls at the edge where tx_serial completes the stop bit.
- Frame period with ce held high: (DATA_BITS+2)·CLKS_PER_BIT+1 cycles (81 with defaults).
- Rx: the synchroniser adds 2 cycles. The data sample for bit k occurs (k+1.5)·CLKS_PER_BIT cycles (+2) after the start falling edge.
- rx_finish rises about 2 + (DATA_BITS+1.5)·CLKS_PER_BIT cycles after the start edge: ≈ 78 cycles for 8/8. This is before the transmitter finishes its stop bit.
- rx_data and rx_finish update on the same edge.
- Tolerance: correct reception for a clock mismatch of ±3 % between sender and receiver.

## Test plan
- Reset: rst=1 -> tx_serial=1, tx_busy=0, rx_data=0, rx_finish=0. Release rst with ce=0 -> outputs unchanged for 200 cycles.
- Single frame, loopback (tx_serial→rx_serial): tx_data=8'hA5, ce pulsed one cycle.
  - tx_serial pattern: 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles.
  - tx_busy high for 80 cycles.
  - One rx_finish pulse with rx_data=8'hA5.
- Continuous loopback: ce held 1, tx_data set to a new $random byte every 1500 cycles, 30 words.
  - Every rx_finish carries the tx_data latched at the matching frame start.
  - Exactly one pulse per frame; frame period 81 cycles.
- Boundary values: 8'h00 and 8'hFF looped back -> received exactly. For 8'h00, no false start is detected inside the frame.
- Glitch and framing error on rx_serial:
  - Low pulse of 2 cycles -> no rx_finish.
  - Frame with stop bit forced 0 -> no rx_finish, rx_data unchanged, next valid frame received correctly.
- Mid-frame reset: assert rst at cycle 40 of a frame -> tx_serial=1, tx_busy=0 immediately, no rx_finish, a subsequent frame is received correctly.
